// File: rtl/ddr2_arb_pkg.sv
// Shared constants, FSM encoding and pointer helper for the DDR2 request arbiter.
// Round-robin selection is enabled by defining DDR2_ARB_ROUND_ROBIN_EN.
package ddr2_arb_pkg;

    localparam int N_REQ = 5;
    localparam int ID_W  = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RELEASE   = 2'd3
    } arb_state_t;

    // Next requester index after id, wrapping the last requester back to 0.
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_W'(N_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

endpackage

// File: rtl/ddr2_arb_pick.sv
// Combinational winner picker: first set request bit at or above start, wrapping.
// With start tied to 0 this is plain fixed priority, bit 0 highest.
module ddr2_arb_pick
    import ddr2_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  start,
    output logic [N_REQ-1:0] pick,
    output logic [ID_W-1:0]  id
);

    logic w_found;
    int   w_idx;

    always_comb begin
        pick    = '0;
        id      = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = (int'(start) + i) % N_REQ;
            if (!w_found && req[w_idx]) begin
                pick[w_idx] = 1'b1;
                id          = ID_W'(w_idx);
                w_found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr2_req_arb.sv
// Five-way DDR2 command-port arbiter: grant, issue, wait for done, one-cycle release.
// Define DDR2_ARB_ROUND_ROBIN_EN to rotate priority after every completed grant.
module ddr2_req_arb #(
    parameter int N_REQ          = 5,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int TO_W           = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [2:0]       gnt_id,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    input  logic             done,
    output logic             busy,
    output logic             timeout_err
);
    import ddr2_arb_pkg::*;

    if (N_REQ != ddr2_arb_pkg::N_REQ) begin : g_bad_nreq
        $error("ddr2_req_arb: N_REQ must be 5");
    end
    if ((64'd1 << TO_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_tow
        $error("ddr2_req_arb: TO_W too narrow for TIMEOUT_CYCLES");
    end

    // Last WAIT_DONE cycle before a forced release.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    arb_state_t      r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [ID_W-1:0] r_gnt_id;
    logic            r_cmd_valid;
    logic            r_busy;
    logic            r_timeout_err;
    logic [TO_W-1:0] r_cnt;
    logic [N_REQ-1:0] w_pick;
    logic [ID_W-1:0] w_pick_id;
    logic [ID_W-1:0] w_start;

`ifdef DDR2_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (r_state == WAIT_DONE && (done || r_cnt == TO_LAST)) begin
            r_ptr <= next_id(r_gnt_id);
        end
    end

    assign w_start = r_ptr;
`else
    assign w_start = '0;
`endif

    ddr2_arb_pick u_pick (
        .req   (req),
        .start (w_start),
        .pick  (w_pick),
        .id    (w_pick_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_gnt         <= '0;
            r_gnt_id      <= '0;
            r_cmd_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_gnt       <= w_pick;
                        r_gnt_id    <= w_pick_id;
                        r_cmd_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Acceptance beats a simultaneous request drop.
                    if (cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= WAIT_DONE;
                    end else if (!(|(req & r_gnt))) begin
                        r_gnt       <= '0;
                        r_gnt_id    <= '0;
                        r_cmd_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (done || r_cnt == TO_LAST) begin
                        r_timeout_err <= !done;
                        r_gnt         <= '0;
                        r_gnt_id      <= '0;
                        r_state       <= RELEASE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign gnt_id      = r_gnt_id;
    assign cmd_valid   = r_cmd_valid;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_ddr2_req_arb.sv
// Scoreboard bench for ddr2_req_arb: driver predicts each grant transaction, monitor checks it.
module tb_ddr2_req_arb;

    localparam int T = 8;

    localparam int M_ABORT  = 0;
    localparam int M_DONE   = 1;
    localparam int M_TO     = 2;
    localparam int M_DONETO = 3;
    localparam int M_RST    = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req;
    logic [4:0] gnt;
    logic [2:0] gnt_id;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       done;
    logic       busy;
    logic       timeout_err;

    ddr2_req_arb #(.N_REQ(5), .TIMEOUT_CYCLES(T), .TO_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .gnt         (gnt),
        .gnt_id      (gnt_id),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .done        (done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        bit to;
        bit rel;
    } end_t;

    int   id_q[$];
    end_t end_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_txn  = 0;
    int   n_gnts = 0;
    int   ptr    = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference selection: first requesting index scanning upward from the rotation point.
    function automatic int model_pick(input logic [4:0] r);
        for (int i = 0; i < 5; i++) begin
            if (r[(ptr + i) % 5]) return (ptr + i) % 5;
        end
        return -1;
    endfunction

    task automatic push_end(input int len, input bit to, input bit rel);
        end_t e;
        e.len = len;
        e.to  = to;
        e.rel = rel;
        end_q.push_back(e);
    endtask

    // One grant transaction. k: issue cycles before accept/abort; j: WAIT_DONE cycle of done.
    task automatic txn(input logic [4:0] r, input int mode, input int k, input int j,
                       input bit done_in_issue, input bit drop_at_ready);
        int         id;
        int         n;
        logic [4:0] bitm;
        id   = model_pick(r);
        bitm = 5'(1 << id);
        id_q.push_back(id);
        n_txn++;
        req = r;
        tick();
        n = 0;
        for (int i = 0; i < k; i++) begin
            done = done_in_issue && (i == 0);
            tick();
            n++;
            done = 1'b0;
        end
        if (mode == M_ABORT) begin
            req = r & ~bitm;
            push_end(n + 1, 1'b0, 1'b0);
            tick();
            req = '0;
        end else begin
            cmd_ready = 1'b1;
            if (drop_at_ready) req = r & ~bitm;
            tick();
            n++;
            cmd_ready = 1'b0;
            req = 5'($urandom_range(0, 31));
            case (mode)
                M_DONE: begin
                    repeat (j - 1) begin tick(); n++; end
                    done = 1'b1;
                    push_end(n + 1, 1'b0, 1'b1);
                    tick();
                    done = 1'b0;
                end
                M_TO: begin
                    repeat (T - 1) begin tick(); n++; end
                    push_end(n + 1, 1'b1, 1'b1);
                    tick();
                end
                M_DONETO: begin
                    repeat (T - 1) begin tick(); n++; end
                    done = 1'b1;
                    push_end(n + 1, 1'b0, 1'b1);
                    tick();
                    done = 1'b0;
                end
                default: begin
                    repeat (j - 1) begin tick(); n++; end
                    rst = 1'b1;
                    push_end(n + 1, 1'b0, 1'b0);
                    tick();
                    rst = 1'b0;
                end
            endcase
            req = '0;
`ifdef DDR2_ARB_ROUND_ROBIN_EN
            if (mode == M_RST) ptr = 0;
            else ptr = (id + 1) % 5;
`endif
        end
        tick();
        tick();
    endtask

    // Monitor: decoupled from the driver, pops expectations on grant start and end.
    logic [4:0] prev_gnt = '0;
    int         run      = 0;
    bit         after    = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("gnt_onehot_id", int'(gnt == 5'b0 ? gnt_id == 3'd0
                                     : (gnt_id < 3'd5 && gnt == 5'(1 << gnt_id))), 1);
            if (after) begin
                chk("idle_busy", int'(busy), 0);
                after = 1'b0;
            end
            if (gnt != 5'b0 && prev_gnt == 5'b0) begin
                n_gnts++;
                if (id_q.size() == 0) begin
                    chk("unexpected_grant", int'(gnt_id), -1);
                end else begin
                    chk("grant_id", int'(gnt_id), id_q.pop_front());
                    chk("grant_cmd_valid", int'(cmd_valid), 1);
                    chk("grant_busy", int'(busy), 1);
                end
                run = 0;
            end
            if (gnt != 5'b0 && prev_gnt != 5'b0 && gnt != prev_gnt)
                chk("grant_changed", int'(gnt), int'(prev_gnt));
            if (gnt != 5'b0) run++;
            if (gnt == 5'b0 && prev_gnt != 5'b0) begin
                if (end_q.size() == 0) begin
                    chk("unexpected_release", run, -1);
                end else begin
                    end_t e;
                    e = end_q.pop_front();
                    chk("grant_len", run, e.len);
                    chk("timeout_err", int'(timeout_err), int'(e.to));
                    chk("release_busy", int'(busy), int'(e.rel));
                    chk("release_cmd_valid", int'(cmd_valid), 0);
                end
                after = 1'b1;
            end else if (timeout_err) begin
                chk("stray_timeout_err", int'(timeout_err), 0);
            end
            prev_gnt = gnt;
        end
    end

    initial begin
        rst       = 1'b1;
        req       = '0;
        cmd_ready = 1'b0;
        done      = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_gnt", int'(gnt), 0);
        chk("reset_gnt_id", int'(gnt_id), 0);
        chk("reset_cmd_valid", int'(cmd_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_timeout_err", int'(timeout_err), 0);
        mon_en = 1'b1;
        tick();

        txn(5'b00100, M_RST, 1, 3, 1'b0, 1'b0);
        txn(5'b10110, M_DONE, 2, 3, 1'b0, 1'b0);
        txn(5'b10110, M_DONE, 2, 3, 1'b0, 1'b0);
        txn(5'b01000, M_ABORT, 2, 1, 1'b0, 1'b0);
        txn(5'b00001, M_TO, 0, 1, 1'b0, 1'b0);
        txn(5'b00001, M_DONETO, 0, 1, 1'b0, 1'b0);
        repeat (6) txn(5'b11111, M_DONE, 0, 1, 1'b0, 1'b0);
        txn(5'b00010, M_DONE, 2, 2, 1'b1, 1'b1);
        txn(5'b10100, M_DONE, 1, 1, 1'b0, 1'b1);

        for (int t = 0; t < 60; t++) begin
            int  k;
            int  j;
            bit  di;
            k  = $urandom_range(0, 3);
            j  = $urandom_range(1, T - 1);
            di = (k > 0) && ($urandom_range(0, 1) == 1);
            txn(5'($urandom_range(1, 31)), $urandom_range(0, 4), k, j, di,
                $urandom_range(0, 3) == 0);
        end

        repeat (4) tick();
        chk("grant_queue_drained", id_q.size(), 0);
        chk("release_queue_drained", end_q.size(), 0);
        chk("grant_count", n_gnts, n_txn);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
